// File: rtl/calc_display_pkg.sv
// Shared codes for calc_display: status encodings, FSM states, glyph codes and
// active-low seven-segment patterns (bit order g..a).
package calc_disp_pkg;

  localparam logic [1:0] ST_ERR   = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;
  localparam logic [1:0] ST_PRINT = 2'b11;

  typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT, ERROR} state_t;

  // Glyph codes 0..9 are the decimal digits; 10..15 fall through to blank.
  typedef logic [4:0] glyph_t;
  localparam glyph_t GL_BLANK = 5'd16;
  localparam glyph_t GL_E     = 5'd17;
  localparam glyph_t GL_R     = 5'd18;
  localparam glyph_t GL_O     = 5'd19;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_O     = 7'h23;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/calc_display_seg7.sv
// Glyph code to active-low seven-segment pattern; unknown codes are blank.
module seg7_decoder
  import calc_disp_pkg::*;
(
  input  logic [4:0] glyph,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (glyph)
      5'd0:    seg = SEG_0;
      5'd1:    seg = SEG_1;
      5'd2:    seg = SEG_2;
      5'd3:    seg = SEG_3;
      5'd4:    seg = SEG_4;
      5'd5:    seg = SEG_5;
      5'd6:    seg = SEG_6;
      5'd7:    seg = SEG_7;
      5'd8:    seg = SEG_8;
      5'd9:    seg = SEG_9;
      GL_E:    seg = SEG_E;
      GL_R:    seg = SEG_R;
      GL_O:    seg = SEG_O;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/calc_display.sv
// Captures the calculator print stream into a shadow buffer, commits whole frames
// and multiplexes 8 digits. Define CALC_DISPLAY_LZ_BLANK_EN to blank leading zeros.
module calc_display
  import calc_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] an,
  output logic [7:0] seg,
  output logic       frame_done,
  output logic       err
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);

  state_t          state;
  logic [7:0][3:0] shadow, shadow_nxt, disp;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic            capture;
  glyph_t          glyph;
  logic [6:0]      seg7;

  assign capture = (status == ST_PRINT) && (pos >= 4'd1) && (pos <= 4'd8);

  // pos 1..8 maps to index 0..7; the 3-bit wrap turns pos 8 (low bits 000) into 7.
  always_comb begin
    shadow_nxt = shadow;
    if (capture) shadow_nxt[pos[2:0] - 3'd1] = data;
  end

  // The commit copy and pulse are issued on the edge entering COMMIT so both are
  // visible during the COMMIT cycle, one cycle after the pos==8 sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shadow     <= '0;
      disp       <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (status == ST_ERR || state == ERROR) begin
        state  <= ERROR;
        err    <= 1'b1;
        shadow <= '0;
      end else begin
        case (state)
          IDLE: if (capture) begin
            shadow <= shadow_nxt;
            state  <= CAPTURE;
          end
          CAPTURE: if (capture) begin
            shadow <= shadow_nxt;
            if (pos == 4'd8) begin
              disp       <= shadow_nxt;
              frame_done <= 1'b1;
              state      <= COMMIT;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(REFRESH_DIV - 1)) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign an = ~(8'd1 << idx);

`ifdef CALC_DISPLAY_LZ_BLANK_EN
  logic [2:0] msnz;
  always_comb begin
    msnz = '0;
    for (int unsigned i = 1; i < 8; i++)
      if (disp[i] != '0) msnz = 3'(i);
  end
`endif

  always_comb begin
    glyph = GL_BLANK;
    if (err) begin
      case (idx)
        3'd3:        glyph = GL_E;
        3'd2, 3'd1:  glyph = GL_R;
        3'd0:        glyph = GL_O;
        default:     glyph = GL_BLANK;
      endcase
    end else begin
      glyph = (disp[idx] > 4'd9) ? GL_BLANK : {1'b0, disp[idx]};
`ifdef CALC_DISPLAY_LZ_BLANK_EN
      if (idx > msnz) glyph = GL_BLANK;
`endif
    end
  end

  seg7_decoder u_dec (
    .glyph (glyph),
    .seg   (seg7)
  );

  assign seg = {1'b1, seg7};

endmodule

// File: tb/tb_calc_display.sv
// Directed bench for calc_display with a frame scoreboard; honours CALC_DISPLAY_LZ_BLANK_EN.
module tb_calc_display;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] status;
  logic [3:0] data, pos;
  logic [7:0] an, seg;
  logic       frame_done, err;

  calc_display #(.REFRESH_DIV(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .status     (status),
    .data       (data),
    .pos        (pos),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clock = ~clock;

  typedef logic [7:0][3:0] frame_t;
  localparam logic [3:0] BL = 4'd10, LE = 4'd11, LR = 4'd12, LO = 4'd13;

  int     vectors = 0;
  int     miscompares = 0;
  frame_t sb[$];
  int     sh[8];
  bit     live;

  function automatic logic [7:0] seg_of(input logic [3:0] c);
    case (c)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      4'd11:   return 8'h86;
      4'd12:   return 8'hAF;
      4'd13:   return 8'hA3;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic frame_t expect_frame();
    frame_t f;
    int top = 0;
    for (int i = 1; i < 8; i++) if (sh[i] != 0) top = i;
    for (int i = 0; i < 8; i++) begin
      f[i] = (sh[i] > 9) ? BL : 4'(sh[i]);
`ifdef CALC_DISPLAY_LZ_BLANK_EN
      if (i > top) f[i] = BL;
`endif
    end
    return f;
  endfunction

  function automatic frame_t err_frame();
    frame_t f;
    for (int i = 0; i < 8; i++) f[i] = BL;
    f[3] = LE; f[2] = LR; f[1] = LR; f[0] = LO;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cap(input int p, input int d);
    status = 2'b11;
    pos    = 4'(p);
    data   = 4'(d);
    if (live && p >= 1 && p <= 8) begin
      sh[p-1] = d;
      if (p == 8) sb.push_back(expect_frame());
    end
    step();
  endtask

  task automatic check_display(input string tag, input frame_t f);
    for (int n = 0; n < 32; n++) begin
      int k = 0;
      chk({tag, "_an_onehot"}, $countones(~an), 1);
      for (int i = 0; i < 8; i++) if (!an[i]) k = i;
      chk({tag, "_seg"}, seg, seg_of(f[k]));
      step();
    end
  endtask

  task automatic wait_commit(input string tag);
    int     k = 0;
    frame_t e;
    while (!frame_done && k < 4) begin
      step();
      k++;
    end
    chk({tag, "_fd"}, frame_done, 1);
    chk({tag, "_lat"}, k, 0);
    chk({tag, "_sb"}, (sb.size() != 0), 1);
    if (sb.size() != 0) e = sb.pop_front();
    status = 2'b10;
    pos    = 4'd0;
    step();
    chk({tag, "_fd_single"}, frame_done, 0);
    check_display(tag, e);
  endtask

  initial begin
    logic [7:0] exp_an;
    frame_t     f;
    status = 2'b10; pos = 4'd0; data = 4'd0; live = 1'b1;
    for (int i = 0; i < 8; i++) sh[i] = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    chk("rst_an", an, 8'hFE);
    chk("rst_seg", seg, 8'hC0);
    chk("rst_fd", frame_done, 0);
    chk("rst_err", err, 0);

    f = expect_frame();
    for (int n = 0; n < 40; n++) begin
      exp_an = ~(8'd1 << ((n / 4) % 8));
      chk("scan_an", an, exp_an);
      chk("scan_seg", seg, seg_of(f[(n / 4) % 8]));
      step();
    end

    cap(1, 3); cap(2, 2); cap(3, 1); cap(4, 0);
    cap(5, 0); cap(6, 0); cap(7, 0); cap(8, 0);
    wait_commit("frame123");

    cap(1, 0); cap(2, 5); cap(3, 12);
    status = 2'b01; step();
    cap(5, 7); cap(4, 1); cap(4, 0);
    status = 2'b10; step();
    cap(6, 0); cap(7, 0); cap(8, 0);
    wait_commit("frame_ooo");

    cap(1, 8); cap(2, 8); cap(3, 8); cap(4, 8);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) sh[i] = 0;
    #2 reset = 1'b0;
    chk("midrst_an", an, 8'hFE);
    chk("midrst_fd", frame_done, 0);
    chk("midrst_seg", seg, 8'hC0);
    status = 2'b10; step();
    chk("midrst_nocommit", frame_done, 0);
    cap(1, 9); cap(2, 9); cap(3, 0); cap(4, 0);
    cap(5, 0); cap(6, 0); cap(7, 0); cap(8, 0);
    wait_commit("frame99");

    cap(1, 4); cap(2, 5); cap(3, 6); cap(4, 7);
    status = 2'b00;
    live   = 1'b0;
    sb.push_back(err_frame());
    step();
    chk("err_fd", frame_done, 0);
    chk("err_flag", err, 1);
    status = 2'b10; step();
    chk("err_sb", (sb.size() != 0), 1);
    if (sb.size() != 0) f = sb.pop_front();
    check_display("erro", f);
    for (int p = 1; p <= 8; p++) begin
      cap(p, 1);
      chk("err_ignore_fd", frame_done, 0);
    end
    status = 2'b10; step();
    chk("err_sticky", err, 1);
    check_display("erro_sticky", err_frame());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
